// File: rtl/unary_to_bin_pkg.sv
// Shared definitions for the unary-arithmetic blocks: FSM encoding and default widths.
package unary_to_bin_pkg;

  localparam int DEF_BITWIDTH = 8;
  localparam int DEF_WINLOG   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unary_to_bin.sv
// Converts a unary (stochastic) bitstream to a binary ones-density estimate over
// a window of 2^WINLOG valid samples, with a ready/valid result handshake.
module unary_to_bin
  import unary_to_bin_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int WINLOG   = DEF_WINLOG
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iValid,
  input  logic                iBit,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oBin
);

  localparam int SHIFT = WINLOG - BITWIDTH;

  // A full window of ones yields 2^BITWIDTH after the shift, one past the output range.
  function automatic logic [BITWIDTH-1:0] sat_bin(input logic [WINLOG:0] ones_v);
    logic [WINLOG:0] shifted;
    shifted = ones_v >> SHIFT;
    if (|shifted[WINLOG:BITWIDTH]) return {BITWIDTH{1'b1}};
    else                           return shifted[BITWIDTH-1:0];
  endfunction

  state_t              state, state_nxt;
  logic [WINLOG-1:0]   win_cnt;
  logic [WINLOG:0]     ones_cnt;
  logic [WINLOG:0]     ones_nxt;
  logic                win_last;
  logic                cnt_clr, cnt_en, out_load, out_ack, out_zero;

  assign ones_nxt = ones_cnt + {{WINLOG{1'b0}}, iBit};
  assign win_last = (win_cnt == {WINLOG{1'b1}});
  assign oBusy    = (state == ACC);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    out_load  = 1'b0;
    out_ack   = 1'b0;
    out_zero  = 1'b0;
    if (iClr) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
      out_zero  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            state_nxt = ACC;
            cnt_clr   = 1'b1;
          end
        end
        ACC: begin
          if (iValid) begin
            cnt_en = 1'b1;
            if (win_last) begin
              state_nxt = DONE;
              out_load  = 1'b1;
            end
          end
        end
        DONE: begin
          if (iReady) begin
            out_ack = 1'b1;
            if (iStart) begin
              state_nxt = ACC;
              cnt_clr   = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The result is taken from ones_nxt so the final sample lands on the same edge.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      win_cnt  <= '0;
      ones_cnt <= '0;
      oBin     <= '0;
      oValid   <= 1'b0;
    end else begin
      if (cnt_clr) begin
        win_cnt  <= '0;
        ones_cnt <= '0;
      end else if (cnt_en) begin
        win_cnt  <= win_cnt + WINLOG'(1);
        ones_cnt <= ones_nxt;
      end
      if (out_zero) begin
        oBin   <= '0;
        oValid <= 1'b0;
      end else if (out_load) begin
        oBin   <= sat_bin(ones_nxt);
        oValid <= 1'b1;
      end else if (out_ack) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule
